// File: rtl/string_hw_pkg.sv
// rtl/string_hw_pkg.sv - shared constants and types for the string accelerator controller
//
// Purpose: operand sizing, register map, STATUS/CTRL bit positions, op-index
//          and FSM state enums used by string_hw_avalon_ctrl and its bench.
// Ports:   none (package).

package string_hw_pkg;

    localparam int MAX_BLOCKS = 8;
    localparam int NUM_CHARS  = MAX_BLOCKS * 4;

    // Register map (word addresses)
    localparam logic [4:0] ADDR_A_BASE   = 5'h00;
    localparam logic [4:0] ADDR_B_BASE   = 5'h08;
    localparam logic [4:0] ADDR_CTRL     = 5'h10;
    localparam logic [4:0] ADDR_STATUS   = 5'h11;
    localparam logic [4:0] ADDR_RES_BASE = 5'h12;

    // STATUS bit indices
    localparam int ST_BUSY        = 0;
    localparam int ST_DONE        = 1;
    localparam int ST_ERR_INDEX   = 2;
    localparam int ST_ERR_TIMEOUT = 3;
    localparam int ST_OVERRUN     = 4;

    // CTRL bit indices
    localparam int CTRL_IE    = 30;
    localparam int CTRL_START = 31;

    typedef enum logic [3:0] {
        OP_CMP     = 4'd0,
        OP_UPPER   = 4'd1,
        OP_LOWER   = 4'd2,
        OP_REVERSE = 4'd3,
        OP_SEARCH  = 4'd4
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_DONE = 2'd1,
        S_WAIT_CLR  = 2'd2
    } state_e;

    function automatic logic index_valid(input logic [3:0] idx);
        return idx <= 4'(OP_SEARCH);
    endfunction

endpackage

// File: rtl/string_hw_avalon_ctrl.sv
// rtl/string_hw_avalon_ctrl.sv - Avalon-MM register file and go/done initiator for the string accelerator
//
// Purpose: CPU loads operand strings A/B and an op select, writes CTRL.start;
//          the block raises acc_go, waits for acc_done, captures acc_result
//          into RES, drops acc_go and waits for acc_done to fall.
//          Optional feature macro: STRING_HW_CTRL_IRQ_EN (level irq + CTRL.ie).
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   avs_address/read/write/writedata/readdata   Avalon-MM slave, read latency 1
//   irq                   level interrupt to the CPU (0 unless macro defined)
//   acc_go/index/length/A/B   request to the accelerator
//   acc_done/result           response from the accelerator

module string_hw_avalon_ctrl
    import string_hw_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [4:0]                    avs_address,
    input  logic                          avs_read,
    input  logic                          avs_write,
    input  logic [31:0]                   avs_writedata,
    output logic [31:0]                   avs_readdata,
    output logic                          irq,
    output logic                          acc_go,
    output logic [3:0]                    acc_index,
    output logic [7:0]                    acc_length,
    output logic [0:NUM_CHARS-1][7:0]     acc_A,
    output logic [0:NUM_CHARS-1][7:0]     acc_B,
    input  logic                          acc_done,
    input  logic [0:NUM_CHARS-1][7:0]     acc_result
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int AW = $clog2(MAX_BLOCKS);

    logic [31:0]   a_q   [MAX_BLOCKS];
    logic [31:0]   b_q   [MAX_BLOCKS];
    logic [31:0]   res_q [MAX_BLOCKS];
    logic [3:0]    index_q;
    logic [7:0]    length_q;
    logic          done_q;
    logic          err_index_q;
    logic          err_timeout_q;
    logic          overrun_q;
    logic          ie_rd;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q;

    // ---------------- address decode ----------------
    logic          a_hit, b_hit, ctrl_hit, status_hit, res_hit;
    logic [4:0]    res_off;
    logic [AW-1:0] word_sel, res_sel;

    assign a_hit      = (avs_address < ADDR_B_BASE);
    assign b_hit      = (avs_address >= ADDR_B_BASE) && (avs_address < ADDR_CTRL);
    assign ctrl_hit   = (avs_address == ADDR_CTRL);
    assign status_hit = (avs_address == ADDR_STATUS);
    assign res_off    = avs_address - ADDR_RES_BASE;
    assign res_hit    = (avs_address >= ADDR_RES_BASE) && (res_off < 5'(MAX_BLOCKS));
    assign word_sel   = avs_address[AW-1:0];
    assign res_sel    = res_off[AW-1:0];

    logic busy;
    logic start_req;
    logic timeout_now;

    assign busy        = (state_q != S_IDLE);
    assign start_req   = avs_write && ctrl_hit && avs_writedata[CTRL_START];
    assign timeout_now = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    // ---------------- FSM next state ----------------
    logic launch, capture, finish_ok, timeout_hit;

    always_comb begin
        state_d     = state_q;
        launch      = 1'b0;
        capture     = 1'b0;
        finish_ok   = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_req && index_valid(avs_writedata[3:0])) begin
                    launch  = 1'b1;
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                // A done arriving on the last allowed cycle still counts as success.
                if (acc_done) begin
                    capture = 1'b1;
                    state_d = S_WAIT_CLR;
                end else if (timeout_now) begin
                    timeout_hit = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            S_WAIT_CLR: begin
                if (!acc_done) begin
                    finish_ok = 1'b1;
                    state_d   = S_IDLE;
                end else if (timeout_now) begin
                    timeout_hit = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            // Counter restarts on every state change and idles at zero.
            if (state_d != state_q || state_q == S_IDLE) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // acc_go follows the state register directly, so it rises the cycle after
    // the start write and drops asynchronously with reset.
    assign acc_go = (state_q == S_WAIT_DONE);

    // ---------------- register file ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < MAX_BLOCKS; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                res_q[k] <= '0;
            end
            index_q       <= '0;
            length_q      <= '0;
            done_q        <= 1'b0;
            err_index_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            // Operands and op select are frozen while an op is in flight.
            if (avs_write && !busy) begin
                if (a_hit) a_q[word_sel] <= avs_writedata;
                if (b_hit) b_q[word_sel] <= avs_writedata;
                if (ctrl_hit) begin
                    index_q  <= avs_writedata[3:0];
                    length_q <= avs_writedata[15:8];
                end
            end

            // Write-1-to-clear first; the event sets below override it.
            if (avs_write && status_hit) begin
                if (avs_writedata[ST_DONE])        done_q        <= 1'b0;
                if (avs_writedata[ST_ERR_INDEX])   err_index_q   <= 1'b0;
                if (avs_writedata[ST_ERR_TIMEOUT]) err_timeout_q <= 1'b0;
                if (avs_writedata[ST_OVERRUN])     overrun_q     <= 1'b0;
            end

            if (start_req) begin
                if (busy) begin
                    overrun_q <= 1'b1;
                end else if (launch) begin
                    done_q        <= 1'b0;
                    err_index_q   <= 1'b0;
                    err_timeout_q <= 1'b0;
                end else begin
                    err_index_q <= 1'b1;
                end
            end

            if (capture) begin
                for (int k = 0; k < MAX_BLOCKS; k++) begin
                    for (int b = 0; b < 4; b++) begin
                        res_q[k][8*b +: 8] <= acc_result[4*k + b];
                    end
                end
            end

            if (finish_ok) done_q <= 1'b1;

            if (timeout_hit) begin
                err_timeout_q <= 1'b1;
                done_q        <= 1'b0;
            end
        end
    end

`ifdef STRING_HW_CTRL_IRQ_EN
    logic ie_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ie_q <= 1'b0;
        end else if (avs_write && ctrl_hit && !busy) begin
            ie_q <= avs_writedata[CTRL_IE];
        end
    end

    assign ie_rd = ie_q;
    assign irq   = ie_q & (done_q | err_index_q | err_timeout_q);
`else
    assign ie_rd = 1'b0;
    assign irq   = 1'b0;
`endif

    // ---------------- accelerator operand wiring ----------------
    assign acc_index  = index_q;
    assign acc_length = length_q;

    always_comb begin
        acc_A = '0;
        acc_B = '0;
        for (int k = 0; k < MAX_BLOCKS; k++) begin
            for (int b = 0; b < 4; b++) begin
                acc_A[4*k + b] = a_q[k][8*b +: 8];
                acc_B[4*k + b] = b_q[k][8*b +: 8];
            end
        end
    end

    // ---------------- read path ----------------
    logic [31:0] rd_data;

    always_comb begin
        rd_data = '0;
        if (a_hit) begin
            rd_data = a_q[word_sel];
        end else if (b_hit) begin
            rd_data = b_q[word_sel];
        end else if (ctrl_hit) begin
            rd_data = {1'b0, ie_rd, 14'b0, length_q, 4'b0, index_q};
        end else if (status_hit) begin
            rd_data = {27'b0, overrun_q, err_timeout_q, err_index_q, done_q, busy};
        end else if (res_hit) begin
            rd_data = res_q[res_sel];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            avs_readdata <= '0;
        end else if (avs_read) begin
            avs_readdata <= rd_data;
        end
    end

endmodule

// File: tb/tb_string_hw_avalon_ctrl.sv
// tb/tb_string_hw_avalon_ctrl.sv - directed self-checking bench for string_hw_avalon_ctrl

module tb_string_hw_avalon_ctrl;
    import string_hw_pkg::*;

    typedef logic [0:NUM_CHARS-1][7:0] str_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  avs_address = '0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [31:0] avs_readdata;
    logic        irq;
    logic        acc_go;
    logic [3:0]  acc_index;
    logic [7:0]  acc_length;
    str_t        acc_A, acc_B;
    logic        acc_done;
    str_t        acc_result;

    int vectors = 0;
    int miscompares = 0;
    int done_delay = 2;
    bit never_done = 1'b0;

    string_hw_avalon_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata),
        .irq           (irq),
        .acc_go        (acc_go),
        .acc_index     (acc_index),
        .acc_length    (acc_length),
        .acc_A         (acc_A),
        .acc_B         (acc_B),
        .acc_done      (acc_done),
        .acc_result    (acc_result)
    );

    always #5 clk = ~clk;

    // Behavioural accelerator: done after a programmable delay, held while go is high.
    function automatic str_t model_result();
        str_t r;
        r = '0;
        case (acc_index)
            4'd0: r[NUM_CHARS-1] = (acc_A == acc_B) ? 8'd1 : 8'd0;
            4'd1: for (int i = 0; i < NUM_CHARS; i++)
                      r[i] = (acc_A[i] >= 8'h61 && acc_A[i] <= 8'h7A) ? acc_A[i] - 8'h20 : acc_A[i];
            4'd2: for (int i = 0; i < NUM_CHARS; i++)
                      r[i] = (acc_A[i] >= 8'h41 && acc_A[i] <= 8'h5A) ? acc_A[i] + 8'h20 : acc_A[i];
            4'd3: for (int i = 0; i < NUM_CHARS; i++) r[i] = acc_A[NUM_CHARS-1-i];
            default: r = '0;
        endcase
        return r;
    endfunction

    initial begin
        int cnt;
        cnt = 0;
        acc_done = 1'b0;
        acc_result = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                acc_done = 1'b0;
                cnt = 0;
            end else if (acc_go && !acc_done) begin
                if (!never_done) begin
                    if (cnt >= done_delay) begin
                        acc_result = model_result();
                        acc_done = 1'b1;
                        cnt = 0;
                    end else begin
                        cnt++;
                    end
                end
            end else if (!acc_go) begin
                acc_done = 1'b0;
                cnt = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Bus tasks are entered on a falling edge and return on the next one.
    task automatic av_write(input logic [4:0] addr, input logic [31:0] data);
        avs_address = addr;
        avs_writedata = data;
        avs_write = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
    endtask

    task automatic av_read(input logic [4:0] addr, output logic [31:0] data);
        avs_address = addr;
        avs_read = 1'b1;
        @(negedge clk);
        avs_read = 1'b0;
        data = avs_readdata;
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] s;
        int n;
        n = 0;
        s = 32'h1;
        while (s[0] && n < 300) begin
            av_read(ADDR_STATUS, s);
            n++;
        end
        check(tag, {31'b0, s[0]}, 32'h0);
    endtask

    task automatic wait_go(input logic level, input string tag);
        int n;
        n = 0;
        while (acc_go !== level && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'b0, acc_go}, {31'b0, level});
    endtask

    initial begin
        logic [31:0] rd;
        int n;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        check("rst_readdata", avs_readdata, 32'h0);
        check("rst_go", {31'b0, acc_go}, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        av_read(ADDR_STATUS, rd);
        check("rst_status", rd, 32'h0);
        av_read(ADDR_CTRL, rd);
        check("rst_ctrl", rd, 32'h0);

        // ---- upper: "hello world!" ----
        done_delay = 3;
        av_write(5'h00, 32'h6C6C6568);   // "hell"
        av_write(5'h01, 32'h6F77206F);   // "o wo"
        av_write(5'h02, 32'h21646C72);   // "rld!"
        check("a_char0", {24'b0, acc_A[0]}, 32'h68);
        check("a_char5", {24'b0, acc_A[5]}, 32'h20);
        check("go_before_start", {31'b0, acc_go}, 32'h0);
        av_write(ADDR_CTRL, 32'h8000_0501);
        check("go_one_cycle_later", {31'b0, acc_go}, 32'h1);
        check("acc_index_upper", {28'b0, acc_index}, 32'h1);
        check("acc_length_upper", {24'b0, acc_length}, 32'h5);
        av_read(ADDR_CTRL, rd);
        check("ctrl_readback", rd, 32'h0000_0501);
        wait_idle("upper_idle");
        av_read(ADDR_STATUS, rd);
        check("upper_status", rd, 32'h2);
        av_read(ADDR_RES_BASE, rd);
        check("upper_res0", rd, 32'h4C4C4548);
        av_read(ADDR_RES_BASE + 5'd1, rd);
        check("upper_res1", rd, 32'h4F57204F);
        av_read(ADDR_RES_BASE + 5'd2, rd);
        check("upper_res2", rd, 32'h21444C52);
        av_read(5'h1F, rd);
        check("unmapped_read", rd, 32'h0);

        // ---- compare A == B ----
        done_delay = 2;
        av_write(5'h08, 32'h6C6C6568);
        av_write(5'h09, 32'h6F77206F);
        av_write(5'h0A, 32'h21646C72);
        av_write(ADDR_CTRL, 32'h8000_0000);
        wait_go(1'b0, "cmp_go_fall");
        av_read(ADDR_STATUS, rd);
        check("cmp_go_low_before_done", rd, 32'h1);
        wait_idle("cmp_idle");
        av_read(ADDR_STATUS, rd);
        check("cmp_status", rd, 32'h2);
        av_read(ADDR_RES_BASE + 5'd7, rd);
        check("cmp_res7", rd, 32'h0100_0000);
        av_read(ADDR_RES_BASE, rd);
        check("cmp_res0", rd, 32'h0);

        // ---- invalid index ----
        av_write(ADDR_STATUS, 32'h1E);
        av_read(ADDR_STATUS, rd);
        check("clear_status", rd, 32'h0);
        av_write(ADDR_CTRL, 32'h8000_0007);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            if (acc_go) n++;
            @(negedge clk);
        end
        check("inv_go_never", n, 32'h0);
        av_read(ADDR_STATUS, rd);
        check("inv_status", rd, 32'h4);

        // ---- overrun ----
        av_write(ADDR_STATUS, 32'h1E);
        done_delay = 20;
        av_write(ADDR_CTRL, 32'h8000_0001);
        check("ovr_go", {31'b0, acc_go}, 32'h1);
        av_write(ADDR_CTRL, 32'h8000_0002);
        av_write(5'h00, 32'hDEADBEEF);
        check("ovr_acc_a_stable", {24'b0, acc_A[0]}, 32'h68);
        check("ovr_index_stable", {28'b0, acc_index}, 32'h1);
        wait_idle("ovr_idle");
        av_read(ADDR_STATUS, rd);
        check("ovr_status", rd, 32'h12);
        av_read(ADDR_RES_BASE, rd);
        check("ovr_res0", rd, 32'h4C4C4548);
        av_read(5'h00, rd);
        check("ovr_a0_kept", rd, 32'h6C6C6568);

        // ---- timeout ----
        av_write(ADDR_STATUS, 32'h1E);
        never_done = 1'b1;
        av_write(ADDR_CTRL, 32'h8000_0002);
        n = 0;
        while (acc_go && n < 1200) begin
            n++;
            @(negedge clk);
        end
        check("tmo_go_low", {31'b0, acc_go}, 32'h0);
        check("tmo_length", {31'b0, (n >= 1023 && n <= 1025)}, 32'h1);
        av_read(ADDR_STATUS, rd);
        check("tmo_status", rd, 32'h8);
        av_read(ADDR_RES_BASE, rd);
        check("tmo_res_unchanged", rd, 32'h4C4C4548);

        // ---- reset mid-op ----
        av_read(ADDR_RES_BASE, rd);
        av_write(ADDR_CTRL, 32'h8000_0003);
        check("rmo_go_high", {31'b0, acc_go}, 32'h1);
        #2;
        reset = 1'b0;
        #1;
        check("rmo_go", {31'b0, acc_go}, 32'h0);
        check("rmo_readdata", avs_readdata, 32'h0);
        check("rmo_irq", {31'b0, irq}, 32'h0);
        @(negedge clk);
        never_done = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        av_read(ADDR_STATUS, rd);
        check("rmo_status", rd, 32'h0);
        av_read(ADDR_RES_BASE, rd);
        check("rmo_res0", rd, 32'h0);
        av_read(5'h00, rd);
        check("rmo_a0", rd, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
